var_state_cell: RTL and testbench
=================================

Name: var_state_cell

Overview:
- Per-variable assignment register that sits directly upstream of the literal cells.
- Drives the 3-bit var_value bus consumed by every lit1 instance of that variable: [2:1] is the value and [0] is the implied flag.
- Absorbs implication requests returned by the clause array, takes decisions from the search controller, and unassigns itself on backtrack.
- One instance per variable in the bin.

Parameters:
LEVEL_W, 8, width of decision-level fields.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_i  in  1  direct load strobe (bin load/restore)
wr_value_i  in  3  load value: [2:1] value code, [0] implied flag
wr_level_i  in  LEVEL_W  load decision level
decide_i  in  1  decision strobe from controller
decide_value_i  in  2  decision value code (1 false, 2 true)
cur_level_i  in  LEVEL_W  current decision level
imp_i  in  2  wired-OR implication from clause array (0 none, 1 false, 2 true, 3 both)
backtrack_i  in  1  backtrack strobe
bt_level_i  in  LEVEL_W  backtrack target level
var_value_o  out  3  to lit cells: [2:1] value code, [0] implied
level_o  out  LEVEL_W  level at which the variable was assigned
conflict_o  out  1  variable in conflict state
imp_pulse_o  out  1  one-cycle pulse when a new implication is taken
assigned_o  out  1  value code != 0

Behaviour:
- Value codes: 0 free, 1 false, 2 true, 3 conflict.
- States: FREE, DECIDED, IMPLIED, CONFLICT. All outputs are registered; an accepted event is visible on outputs the cycle after the sampling edge.
- Reset (asynchronous, immediate): FREE, var_value_o=0, level_o=0, conflict_o=0, imp_pulse_o=0, assigned_o=0.
- Priority per cycle is wr_i > backtrack_i > decide_i > imp_i. Lower-priority inputs in the same cycle are ignored, not queued.
- wr_i: load value and level verbatim; the state follows the code:
  - 0 -> FREE
  - 3 -> CONFLICT
  - else implied flag ? IMPLIED : DECIDED
  - imp_pulse_o stays 0.
- backtrack_i: if state != FREE and level_o > bt_level_i -> FREE, var_value_o=0, level_o=0, conflict_o=0. Otherwise no change; equal level is retained.
- decide_i:
  - FREE: -> DECIDED, value=decide_value_i, implied=0, level_o=cur_level_i.
  - Any other state: ignored.
  - decide_value_i of 0 or 3 is ignored.
- imp_i in FREE:
  - 1 or 2 -> IMPLIED, value=imp_i, implied=1, level_o=cur_level_i, imp_pulse_o=1 for exactly one cycle.
  - 3 -> CONFLICT, value=3, level_o=cur_level_i, conflict_o=1, no pulse.
- imp_i in DECIDED/IMPLIED:
  - Equal to the current value, or 0: no change.
  - Opposite value or 3 -> CONFLICT, value=3, implied bit kept, level_o unchanged.
- CONFLICT: only wr_i, reset or a qualifying backtrack leaves it; imp_i and decide_i are ignored.
- Simultaneous decide_i and imp_i in FREE: the decision wins. A still-driven opposing imp_i then produces CONFLICT on the following cycle.
- imp_pulse_o is never asserted on two consecutive cycles, because it fires only on the FREE->IMPLIED transition.
- assigned_o = (var_value_o[2:1] != 0), registered alongside the value.
- Reset asserted mid-operation overrides everything asynchronously. First state change after deassertion is on the next clk edge.

Decomposition:
- Shared package sat_pkg holds:
  - value-code constants VAL_FREE=0, VAL_FALSE=1, VAL_TRUE=2, VAL_CONFLICT=3;
  - the var_state_t enum (FREE, DECIDED, IMPLIED, CONFLICT);
  - LEVEL_W default constant.
- No sub-module. Single always_ff state/data register plus a small next-state combinational block.

Test Plan:
- Reset then idle: rst=1 mid-cycle -> outputs 0 immediately; after release, var_value_o=3'b000 and level_o=0 with imp_i=0.
- Decide: cur_level_i=3, decide_i=1, decide_value_i=2 -> next cycle var_value_o=3'b100, level_o=3, assigned_o=1, imp_pulse_o=0.
- Implication: FREE, cur_level_i=5, imp_i=1 held two cycles -> var_value_o=3'b011, level_o=5, imp_pulse_o=1 for one cycle only.
- Conflict: after the decide scenario, imp_i=1 -> var_value_o[2:1]=3, conflict_o=1, level_o=3; a further decide_i is ignored.
- Backtrack boundary: level_o=3, bt_level_i=3 -> unchanged; bt_level_i=2 -> FREE, var_value_o=0, conflict_o=0.
- Priority: wr_i=1 with wr_value_i=3'b101, wr_level_i=7, plus backtrack_i and imp_i=1 in the same cycle -> var_value_o=3'b101, level_o=7, imp_pulse_o=0.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared SAT-engine types: value codes, per-variable state enum, default level width.
package sat_pkg;

  localparam int unsigned LEVEL_W_DEFAULT = 8;

  localparam logic [1:0] VAL_FREE     = 2'd0;
  localparam logic [1:0] VAL_FALSE    = 2'd1;
  localparam logic [1:0] VAL_TRUE     = 2'd2;
  localparam logic [1:0] VAL_CONFLICT = 2'd3;

  typedef enum logic [1:0] {
    FREE,
    DECIDED,
    IMPLIED,
    CONFLICT
  } var_state_t;

  // State implied by a directly loaded value code and implied flag.
  function automatic var_state_t state_from_code(input logic [1:0] code, input logic implied);
    if (code == VAL_FREE) begin
      return FREE;
    end else if (code == VAL_CONFLICT) begin
      return CONFLICT;
    end else if (implied) begin
      return IMPLIED;
    end else begin
      return DECIDED;
    end
  endfunction

endpackage

// File: rtl/var_state_cell.sv
// Per-variable assignment register feeding the literal cells of one variable.
// Takes direct loads, backtracks, decisions and clause-array implications in that priority.
module var_state_cell
  import sat_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic [2:0]         wr_value_i,
  input  logic [LEVEL_W-1:0] wr_level_i,
  input  logic               decide_i,
  input  logic [1:0]         decide_value_i,
  input  logic [LEVEL_W-1:0] cur_level_i,
  input  logic [1:0]         imp_i,
  input  logic               backtrack_i,
  input  logic [LEVEL_W-1:0] bt_level_i,
  output logic [2:0]         var_value_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               conflict_o,
  output logic               imp_pulse_o,
  output logic               assigned_o
);

  var_state_t         state_q, state_d;
  logic [1:0]         value_q, value_d;
  logic               implied_q, implied_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               conflict_q, conflict_d;
  logic               pulse_q, pulse_d;
  logic               assigned_q, assigned_d;

  // Next-state selection; any asserted strobe masks every lower-priority strobe this cycle.
  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    implied_d = implied_q;
    level_d   = level_q;
    pulse_d   = 1'b0;

    if (wr_i) begin
      value_d   = wr_value_i[2:1];
      implied_d = wr_value_i[0];
      level_d   = wr_level_i;
      state_d   = state_from_code(wr_value_i[2:1], wr_value_i[0]);
    end else if (backtrack_i) begin
      // Assignments made at the target level itself survive the backtrack.
      if (state_q != FREE && level_q > bt_level_i) begin
        state_d   = FREE;
        value_d   = VAL_FREE;
        implied_d = 1'b0;
        level_d   = '0;
      end
    end else if (decide_i) begin
      if (state_q == FREE && (decide_value_i == VAL_FALSE || decide_value_i == VAL_TRUE)) begin
        state_d   = DECIDED;
        value_d   = decide_value_i;
        implied_d = 1'b0;
        level_d   = cur_level_i;
      end
    end else if (imp_i != VAL_FREE) begin
      unique case (state_q)
        FREE: begin
          level_d   = cur_level_i;
          value_d   = imp_i;
          // A both-ways implication is still an implication, so the flag is set.
          implied_d = 1'b1;
          if (imp_i == VAL_CONFLICT) begin
            state_d = CONFLICT;
          end else begin
            state_d = IMPLIED;
            pulse_d = 1'b1;
          end
        end
        DECIDED, IMPLIED: begin
          // Level and implied flag are kept so the controller can see where it went wrong.
          if (imp_i != value_q) begin
            state_d = CONFLICT;
            value_d = VAL_CONFLICT;
          end
        end
        CONFLICT: ;
      endcase
    end

    conflict_d = (state_d == CONFLICT);
    assigned_d = (value_d != VAL_FREE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      value_q    <= VAL_FREE;
      implied_q  <= 1'b0;
      level_q    <= '0;
      conflict_q <= 1'b0;
      pulse_q    <= 1'b0;
      assigned_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      implied_q  <= implied_d;
      level_q    <= level_d;
      conflict_q <= conflict_d;
      pulse_q    <= pulse_d;
      assigned_q <= assigned_d;
    end
  end

  assign var_value_o = {value_q, implied_q};
  assign level_o     = level_q;
  assign conflict_o  = conflict_q;
  assign imp_pulse_o = pulse_q;
  assign assigned_o  = assigned_q;

endmodule

// File: tb/tb_var_state_cell.sv
// Self-checking bench for var_state_cell: directed vector table, reset corners, random vs model.
module tb_var_state_cell;
  import sat_pkg::*;

  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_i;
  logic [2:0]    wr_value_i;
  logic [LW-1:0] wr_level_i;
  logic          decide_i;
  logic [1:0]    decide_value_i;
  logic [LW-1:0] cur_level_i;
  logic [1:0]    imp_i;
  logic          backtrack_i;
  logic [LW-1:0] bt_level_i;
  logic [2:0]    var_value_o;
  logic [LW-1:0] level_o;
  logic          conflict_o;
  logic          imp_pulse_o;
  logic          assigned_o;

  var_state_cell #(.LEVEL_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_i           (wr_i),
    .wr_value_i     (wr_value_i),
    .wr_level_i     (wr_level_i),
    .decide_i       (decide_i),
    .decide_value_i (decide_value_i),
    .cur_level_i    (cur_level_i),
    .imp_i          (imp_i),
    .backtrack_i    (backtrack_i),
    .bt_level_i     (bt_level_i),
    .var_value_o    (var_value_o),
    .level_o        (level_o),
    .conflict_o     (conflict_o),
    .imp_pulse_o    (imp_pulse_o),
    .assigned_o     (assigned_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: value code, implied flag, level, conflict, pulse.
  int m_code, m_impf, m_lvl, m_conf, m_pulse;

  typedef struct {
    logic          wr;
    logic [2:0]    wv;
    logic [LW-1:0] wl;
    logic          dec;
    logic [1:0]    dv;
    logic [LW-1:0] cur;
    logic [1:0]    imp;
    logic          bt;
    logic [LW-1:0] btl;
    logic [2:0]    e_val;
    logic [LW-1:0] e_lvl;
    logic          e_conf;
    logic          e_pulse;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [2:0] wv, int wl, logic dec, logic [1:0] dv,
                              int cur, logic [1:0] imp, logic bt, int btl,
                              logic [2:0] ev, int el, logic ec, logic ep);
    vec_t v;
    v.wr = wr; v.wv = wv; v.wl = LW'(wl); v.dec = dec; v.dv = dv; v.cur = LW'(cur);
    v.imp = imp; v.bt = bt; v.btl = LW'(btl);
    v.e_val = ev; v.e_lvl = LW'(el); v.e_conf = ec; v.e_pulse = ep;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wr_i = 1'b0; wr_value_i = '0; wr_level_i = '0;
    decide_i = 1'b0; decide_value_i = '0; cur_level_i = '0;
    imp_i = '0; backtrack_i = 1'b0; bt_level_i = '0;
  endtask

  task automatic model_reset();
    m_code = 0; m_impf = 0; m_lvl = 0; m_conf = 0; m_pulse = 0;
  endtask

  // Applies the assignment rules to the currently driven inputs.
  task automatic model_step();
    m_pulse = 0;
    if (wr_i) begin
      m_code = int'(wr_value_i[2:1]);
      m_impf = int'(wr_value_i[0]);
      m_lvl  = int'(wr_level_i);
    end else if (backtrack_i) begin
      if (m_code != 0 && m_lvl > int'(bt_level_i)) begin
        m_code = 0; m_impf = 0; m_lvl = 0;
      end
    end else if (decide_i) begin
      if (m_code == 0 && (decide_value_i == 2'd1 || decide_value_i == 2'd2)) begin
        m_code = int'(decide_value_i); m_impf = 0; m_lvl = int'(cur_level_i);
      end
    end else if (imp_i != 2'd0) begin
      if (m_code == 0) begin
        m_code  = int'(imp_i);
        m_impf  = 1;
        m_lvl   = int'(cur_level_i);
        m_pulse = (imp_i != 2'd3) ? 1 : 0;
      end else if (m_code != 3 && int'(imp_i) != m_code) begin
        m_code = 3;
      end
    end
    m_conf = (m_code == 3) ? 1 : 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".value"},    int'(var_value_o), m_code * 2 + m_impf);
    check({tag, ".level"},    int'(level_o),     m_lvl);
    check({tag, ".conflict"}, int'(conflict_o),  m_conf);
    check({tag, ".pulse"},    int'(imp_pulse_o), m_pulse);
    check({tag, ".assigned"}, int'(assigned_o),  (m_code != 0) ? 1 : 0);
  endtask

  initial begin
    vec_t v;
    int   prev_pulse;

    // wr wv wl  dec dv cur imp bt btl   val lvl conf pulse
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 0, 2'd0, 0, 0, 3'b000, 0, 0, 0)); // idle
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd2, 3, 2'd0, 0, 0, 3'b100, 3, 0, 0)); // decide true
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 3, 2'd1, 0, 0, 3'b110, 3, 1, 0)); // opposing imp
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd1, 4, 2'd0, 0, 0, 3'b110, 3, 1, 0)); // decide ignored
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 4, 2'd0, 1, 3, 3'b110, 3, 1, 0)); // bt equal level
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 4, 2'd0, 1, 2, 3'b000, 0, 0, 0)); // bt below
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 5, 2'd1, 0, 0, 3'b011, 5, 0, 1)); // implied false
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 5, 2'd1, 0, 0, 3'b011, 5, 0, 0)); // held: no pulse
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 5, 2'd2, 0, 0, 3'b111, 5, 1, 0)); // conflict
    tbl.push_back(mk(1, 3'b101, 7, 0, 2'd0, 5, 2'd1, 1, 0, 3'b101, 7, 0, 0)); // wr wins
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 5, 2'd0, 1, 6, 3'b000, 0, 0, 0)); // bt to free
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd1, 2, 2'd2, 0, 0, 3'b010, 2, 0, 0)); // decide beats imp
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 2, 2'd2, 0, 0, 3'b110, 2, 1, 0)); // imp next cycle
    tbl.push_back(mk(1, 3'b000, 9, 0, 2'd0, 2, 2'd0, 0, 0, 3'b000, 9, 0, 0)); // wr free
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 2, 2'd0, 1, 0, 3'b000, 9, 0, 0)); // bt in free
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd3, 1, 2'd0, 0, 0, 3'b000, 9, 0, 0)); // bad decide 3
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd0, 1, 2'd0, 0, 0, 3'b000, 9, 0, 0)); // bad decide 0
    tbl.push_back(mk(1, 3'b111, 4, 0, 2'd0, 1, 2'd0, 0, 0, 3'b111, 4, 1, 0)); // wr conflict
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 1, 2'd1, 0, 0, 3'b111, 4, 1, 0)); // imp ignored
    tbl.push_back(mk(1, 3'b011, 2, 0, 2'd0, 1, 2'd0, 0, 0, 3'b011, 2, 0, 0)); // wr implied
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 1, 2'd1, 0, 0, 3'b011, 2, 0, 0)); // same value
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 1, 2'd3, 0, 0, 3'b111, 2, 1, 0)); // both ways
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd2, 6, 2'd0, 0, 0, 3'b111, 2, 1, 0)); // decide in conf
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 6, 2'd0, 1, 1, 3'b000, 0, 0, 0)); // leave conflict
    tbl.push_back(mk(0, 3'b000, 0, 0, 2'd0, 6, 2'd3, 0, 0, 3'b111, 6, 1, 0)); // free, imp both

    // Reset state while reset is held.
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.value", int'(var_value_o), 0);
    check("reset.level", int'(level_o), 0);
    check("reset.conflict", int'(conflict_o), 0);
    check("reset.pulse", int'(imp_pulse_o), 0);
    check("reset.assigned", int'(assigned_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      wr_i = v.wr; wr_value_i = v.wv; wr_level_i = v.wl;
      decide_i = v.dec; decide_value_i = v.dv; cur_level_i = v.cur;
      imp_i = v.imp; backtrack_i = v.bt; bt_level_i = v.btl;
      cycle();
      check($sformatf("vec%0d.value", i), int'(var_value_o), int'(v.e_val));
      check($sformatf("vec%0d.level", i), int'(level_o), int'(v.e_lvl));
      check($sformatf("vec%0d.conflict", i), int'(conflict_o), int'(v.e_conf));
      check($sformatf("vec%0d.pulse", i), int'(imp_pulse_o), int'(v.e_pulse));
      check($sformatf("vec%0d.assigned", i), int'(assigned_o), (v.e_val[2:1] != 2'd0) ? 1 : 0);
    end

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    drive_idle();
    decide_i = 1'b1; decide_value_i = 2'd2; cur_level_i = 8'd3;
    cycle();
    drive_idle();
    check("pre_async.assigned", int'(assigned_o), 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async.value", int'(var_value_o), 0);
    check("async.level", int'(level_o), 0);
    check("async.assigned", int'(assigned_o), 0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    compare_model("post_reset");

    // Randomised traffic against the model.
    prev_pulse = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      drive_idle();
      wr_i           = ($urandom_range(0, 15) == 0);
      wr_value_i     = 3'($urandom_range(0, 7));
      wr_level_i     = LW'($urandom_range(0, 7));
      backtrack_i    = ($urandom_range(0, 7) == 0);
      bt_level_i     = LW'($urandom_range(0, 7));
      decide_i       = ($urandom_range(0, 4) == 0);
      decide_value_i = 2'($urandom_range(0, 3));
      cur_level_i    = LW'($urandom_range(0, 7));
      imp_i          = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle();
      compare_model($sformatf("rnd%0d", n));
      if (prev_pulse == 1) check($sformatf("rnd%0d.no_double_pulse", n), int'(imp_pulse_o), 0);
      prev_pulse = int'(imp_pulse_o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
